// File: rtl/booth_pp_acc_seq.sv
// ============================================================================
// booth_pp_acc_seq : sequential reducer for Booth radix-16 partial products
//   Feeds one shared 3-input adder with PP pairs, ceil(NUM_PP/2) cycles per op.
//   Optional abort input enabled by defining BOOTH_SEQ_ABORT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module booth_pp_acc_seq #(
  parameter  int LENGTH = 32,
  localparam int NUM_PP = LENGTH/4 + 1,
  localparam int W      = LENGTH*2 + 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
`ifdef BOOTH_SEQ_ABORT_EN
  input  logic              abort,
`endif
  input  logic              pp_valid,
  output logic              pp_ready,
  input  logic [W-1:0]      pp_a,
  input  logic [W-1:0]      pp_b,
  input  logic              pp_ci,
  output logic              busy,
  output logic              done,
  output logic [LENGTH*2-1:0] product
);

  localparam int NUM_PAIRS = (NUM_PP + 1) / 2;
  localparam int CNT_W     = $clog2(NUM_PAIRS) + 1;
  localparam bit ODD_PP    = (NUM_PP % 2) == 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LENGTH*2-1:0]    product_q;
  logic                   last_pair;
  logic [W-1:0]           pp_b_eff;

  assign last_pair = (cnt_q == CNT_W'(NUM_PAIRS - 1));
  // With an odd PP count the final pair carries only one real partial product.
  assign pp_b_eff  = (ODD_PP && last_pair) ? '0 : pp_b;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    pp_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        pp_ready = 1'b1;
        busy     = 1'b1;
        if (pp_valid) begin
          acc_d = acc_q + pp_a + pp_b_eff + {{(W-1){1'b0}}, pp_ci};
          cnt_d = cnt_q + CNT_W'(1);
          if (last_pair) state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef BOOTH_SEQ_ABORT_EN
    // Abort overrides any transfer taken in the same cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= acc_d[LENGTH*2-1:0];
    end
  end

  assign product = product_q;

endmodule

`default_nettype wire
